// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one memory port between instruction fetch and load/store with dmem priority, anti-starvation and a response watchdog
module mem_port_arbiter #(
    parameter int XLEN        = 32,
    parameter int MAX_DSTREAK = 4,
    parameter int TIMEOUT     = 255
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_req_valid,
    output logic            i_req_ready,
    input  logic [XLEN-1:0] i_req_addr,
    output logic            i_resp_valid,
    output logic [XLEN-1:0] i_resp_data,
    input  logic            d_req_valid,
    output logic            d_req_ready,
    input  logic [XLEN-1:0] d_req_addr,
    input  logic [XLEN-1:0] d_req_data,
    input  logic            d_req_fcn,
    input  logic [2:0]      d_req_typ,
    output logic            d_resp_valid,
    output logic [XLEN-1:0] d_resp_data,
    output logic            m_req_valid,
    input  logic            m_req_ready,
    output logic [XLEN-1:0] m_req_addr,
    output logic [XLEN-1:0] m_req_data,
    output logic            m_req_fcn,
    output logic [2:0]      m_req_typ,
    input  logic            m_resp_valid,
    input  logic [XLEN-1:0] m_resp_data,
    output logic            err_timeout,
    output logic            err_stray
);
    typedef enum logic [1:0] {IDLE, WAIT_I, WAIT_D} state_t;
    localparam int WDW = TIMEOUT > 1 ? $clog2(TIMEOUT) : 1;
    state_t         state, state_nx;
    logic [3:0]     streak;
    logic [WDW-1:0] wd;
    logic           held, held_d;
    logic           idle, gnt_d, gnt_i, d_xfer, i_xfer, timeout, wait_end;
    // Arbitration, request mux, response routing and next state; a stalled request keeps its latched grant
    always_comb begin
        state_nx     = state;
        idle         = state == IDLE && !rst;
        gnt_d        = held ? held_d : d_req_valid && !(i_req_valid && streak == 4'(MAX_DSTREAK));
        gnt_i        = held ? !held_d : !gnt_d && i_req_valid;
        m_req_valid  = idle && (gnt_d ? d_req_valid : gnt_i && i_req_valid);
        d_req_ready  = idle && gnt_d && m_req_ready;
        i_req_ready  = idle && gnt_i && m_req_ready;
        m_req_addr   = gnt_d ? d_req_addr : i_req_addr;
        m_req_data   = gnt_d ? d_req_data : '0;
        m_req_fcn    = gnt_d && d_req_fcn;
        m_req_typ    = gnt_d ? d_req_typ : 3'd7;
        d_xfer       = d_req_valid && d_req_ready;
        i_xfer       = i_req_valid && i_req_ready;
        timeout      = TIMEOUT > 0 && state != IDLE && wd == WDW'(TIMEOUT - 1);
        wait_end     = m_resp_valid || timeout;
        i_resp_valid = !rst && state == WAIT_I && wait_end;
        d_resp_valid = !rst && state == WAIT_D && wait_end;
        i_resp_data  = m_resp_valid ? m_resp_data : '0;
        d_resp_data  = m_resp_valid ? m_resp_data : '0;
        state_nx     = idle ? (d_xfer ? WAIT_D : i_xfer ? WAIT_I : IDLE) : (state == IDLE || wait_end) ? IDLE : state;
    end
    // State register plus the grant latch held while the memory stalls a raised request
    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            held   <= 1'b0;
            held_d <= 1'b0;
        end else begin
            state  <= state_nx;
            held   <= m_req_valid && !m_req_ready;
            held_d <= gnt_d;
        end
    end
    // Streak and watchdog counters and the sticky error flags
    always_ff @(posedge clk) begin
        if (rst) begin
            streak      <= '0;
            wd          <= '0;
            err_timeout <= 1'b0;
            err_stray   <= 1'b0;
        end else begin
            wd <= state == IDLE ? '0 : wd + 1'b1;
            if (d_xfer)
                streak <= !i_req_valid ? '0 : streak == 4'(MAX_DSTREAK) ? streak : streak + 4'd1;
            else if (i_xfer)
                streak <= '0;
            if (timeout && !m_resp_valid)
                err_timeout <= 1'b1;
            if (m_resp_valid && state == IDLE)
                err_stray <= 1'b1;
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: directed checks of arbitration, grant latching, watchdog and stray-response handling
module tb_mem_port_arbiter;
    logic        clk = 1'b0, rst = 1'b1;
    logic        i_req_valid = 0, i_req_ready, i_resp_valid;
    logic [31:0] i_req_addr = '0, i_resp_data;
    logic        d_req_valid = 0, d_req_ready, d_req_fcn = 0, d_resp_valid;
    logic [31:0] d_req_addr = '0, d_req_data = '0, d_resp_data;
    logic [2:0]  d_req_typ = '0, m_req_typ;
    logic        m_req_valid, m_req_ready = 0, m_req_fcn, m_resp_valid = 0;
    logic [31:0] m_req_addr, m_req_data, m_resp_data = '0;
    logic        err_timeout, err_stray;
    typedef struct packed {logic d; logic [31:0] data;} exp_t;
    exp_t q[$];
    int   cmp = 0, errs = 0;
    mem_port_arbiter #(.XLEN(32), .MAX_DSTREAK(4), .TIMEOUT(8)) dut (
        .clk(clk), .rst(rst),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_resp_valid(i_resp_valid), .i_resp_data(i_resp_data),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_addr(d_req_addr),
        .d_req_data(d_req_data), .d_req_fcn(d_req_fcn), .d_req_typ(d_req_typ),
        .d_resp_valid(d_resp_valid), .d_resp_data(d_resp_data),
        .m_req_valid(m_req_valid), .m_req_ready(m_req_ready), .m_req_addr(m_req_addr),
        .m_req_data(m_req_data), .m_req_fcn(m_req_fcn), .m_req_typ(m_req_typ),
        .m_resp_valid(m_resp_valid), .m_resp_data(m_resp_data),
        .err_timeout(err_timeout), .err_stray(err_stray)
    );
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        cmp++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask
    task automatic cyc();
        @(posedge clk);
        #1;
    endtask
    task automatic resp(input logic [31:0] data, input logic d);
        m_resp_valid = 1'b1;
        m_resp_data  = data;
        q.push_back(exp_t'{d: d, data: data});
        cyc();
        m_resp_valid = 1'b0;
        m_resp_data  = '0;
    endtask
    // Scoreboard: every delivered response must match the oldest expected one
    always @(negedge clk) begin
        if (i_resp_valid || d_resp_valid) begin
            exp_t e;
            chk("resp_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("resp_is_d", 32'(d_resp_valid), 32'(e.d));
                chk("resp_dual", 32'(i_resp_valid & d_resp_valid), 32'd0);
                chk("resp_data", e.d ? d_resp_data : i_resp_data, e.data);
            end
        end
    end
    initial begin
        #50000;
        $display("FAIL sim_time_limit: observed no finish expected finish");
        $fatal(1);
    end
    initial begin
        string order;
        bit    ed;
        order = "DDDDIDDDDI";
        i_req_valid = 1; m_req_ready = 1;
        cyc(); cyc();
        chk("rst_m_valid", m_req_valid, 0);
        chk("rst_i_ready", i_req_ready, 0);
        chk("rst_d_ready", d_req_ready, 0);
        chk("rst_err_timeout", err_timeout, 0);
        chk("rst_err_stray", err_stray, 0);
        i_req_valid = 0; rst = 0;
        // single fetch
        i_req_valid = 1; i_req_addr = 32'h100; #1;
        chk("t1_m_valid", m_req_valid, 1);
        chk("t1_i_ready", i_req_ready, 1);
        chk("t1_addr", m_req_addr, 32'h100);
        chk("t1_fcn", m_req_fcn, 0);
        chk("t1_typ", m_req_typ, 7);
        chk("t1_data", m_req_data, 0);
        cyc(); i_req_valid = 0; #1;
        chk("t1_busy", m_req_valid, 0);
        cyc();
        resp(32'h13, 0);
        // simultaneous store and fetch
        i_req_valid = 1; i_req_addr = 32'h104;
        d_req_valid = 1; d_req_addr = 32'h2000; d_req_data = 32'hDEADBEEF; d_req_fcn = 1; d_req_typ = 3; #1;
        chk("t2_d_ready", d_req_ready, 1);
        chk("t2_i_ready", i_req_ready, 0);
        chk("t2_fcn", m_req_fcn, 1);
        chk("t2_typ", m_req_typ, 3);
        chk("t2_addr", m_req_addr, 32'h2000);
        chk("t2_data", m_req_data, 32'hDEADBEEF);
        cyc(); d_req_valid = 0; #1;
        chk("t2_wait_i_ready", i_req_ready, 0);
        resp(32'h0, 1); #1;
        chk("t2_next_i_ready", i_req_ready, 1);
        chk("t2_next_addr", m_req_addr, 32'h104);
        chk("t2_next_fcn", m_req_fcn, 0);
        cyc(); i_req_valid = 0;
        resp(32'hABC, 0);
        // anti-starvation grant order
        i_req_valid = 1; d_req_valid = 1; d_req_fcn = 0; d_req_typ = 3;
        for (int n = 0; n < 10; n++) begin
            d_req_addr = 32'h7000 + 32'(n * 4);
            i_req_addr = 32'h100 + 32'(n * 4);
            ed = order[n] == "D";
            #1;
            chk("t3_d_ready", d_req_ready, 32'(ed));
            chk("t3_i_ready", i_req_ready, 32'(!ed));
            chk("t3_addr", m_req_addr, ed ? d_req_addr : i_req_addr);
            cyc();
            resp(32'(n), ed);
        end
        i_req_valid = 0; d_req_valid = 0;
        // stalled dmem request keeps its payload when imem appears
        d_req_valid = 1; d_req_addr = 32'h3000; d_req_typ = 1; m_req_ready = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            chk("t4_m_valid", m_req_valid, 1);
            chk("t4_addr", m_req_addr, 32'h3000);
            chk("t4_d_ready", d_req_ready, 0);
            cyc();
        end
        i_req_valid = 1; i_req_addr = 32'h200; #1;
        chk("t4_hold_addr", m_req_addr, 32'h3000);
        chk("t4_i_ready", i_req_ready, 0);
        m_req_ready = 1; #1;
        chk("t4_d_accept", d_req_ready, 1);
        cyc(); d_req_valid = 0;
        resp(32'h55, 1); #1;
        chk("t4_i_next", i_req_ready, 1);
        chk("t4_i_addr", m_req_addr, 32'h200);
        cyc(); i_req_valid = 0;
        resp(32'h66, 0);
        // stalled imem request keeps its grant when dmem appears
        i_req_valid = 1; i_req_addr = 32'h300; m_req_ready = 0;
        cyc();
        d_req_valid = 1; d_req_addr = 32'h4000; d_req_fcn = 1; d_req_typ = 2; d_req_data = 32'h1234; #1;
        chk("t4b_addr", m_req_addr, 32'h300);
        chk("t4b_fcn", m_req_fcn, 0);
        chk("t4b_d_ready", d_req_ready, 0);
        m_req_ready = 1; #1;
        chk("t4b_i_ready", i_req_ready, 1);
        cyc(); i_req_valid = 0;
        resp(32'h77, 0); #1;
        chk("t4b_d_next", d_req_ready, 1);
        chk("t4b_d_addr", m_req_addr, 32'h4000);
        cyc(); d_req_valid = 0;
        resp(32'h88, 1);
        // watchdog and late response
        d_req_valid = 1; d_req_addr = 32'h5000; d_req_fcn = 0; d_req_typ = 3;
        q.push_back(exp_t'{d: 1'b1, data: 32'h0});
        cyc(); d_req_valid = 0;
        for (int k = 1; k <= 8; k++) begin
            #1;
            chk("t5_d_resp", d_resp_valid, 32'(k == 8));
            cyc();
        end
        #1;
        chk("t5_err_timeout", err_timeout, 1);
        chk("t5_err_stray_pre", err_stray, 0);
        m_resp_valid = 1; m_resp_data = 32'h99; #1;
        chk("t5_late_i", i_resp_valid, 0);
        chk("t5_late_d", d_resp_valid, 0);
        cyc(); m_resp_valid = 0; #1;
        chk("t5_err_stray", err_stray, 1);
        chk("t5_err_timeout_sticky", err_timeout, 1);
        // reset during WAIT_I
        i_req_valid = 1; i_req_addr = 32'h600;
        cyc(); i_req_valid = 0; #1;
        chk("t6_waiting", m_req_valid, 0);
        rst = 1; m_resp_valid = 1; m_resp_data = 32'h42; #1;
        chk("t6_rst_i_resp", i_resp_valid, 0);
        cyc(); rst = 0; m_resp_valid = 0; #1;
        chk("t6_err_timeout", err_timeout, 0);
        chk("t6_err_stray", err_stray, 0);
        chk("t6_m_valid", m_req_valid, 0);
        m_resp_valid = 1; m_resp_data = 32'h43; #1;
        chk("t6_late_i", i_resp_valid, 0);
        cyc(); m_resp_valid = 0; #1;
        chk("t6_err_stray_set", err_stray, 1);
        chk("t6_err_timeout_clr", err_timeout, 0);
        i_req_valid = 1; #1;
        chk("t6_idle_ready", i_req_ready, 1);
        i_req_valid = 0;
        cyc(); cyc(); cyc();
        chk("sb_empty", 32'(q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp, errs);
        $finish;
    end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one memory port between the instruction-fetch requester (imem) and the load/store requester (dmem) of the RV32 single-stage core.
- Sits between the control/datapath request interfaces and the unified memory.
- Accepts one outstanding transaction at a time and routes each response back to the requester that issued it.
- dmem has priority over imem, bounded by an anti-starvation counter; a watchdog terminates lost responses.

Parameters:
- XLEN, 32, address and data width.
- MAX_DSTREAK, 4, consecutive dmem grants allowed while imem waits; range 1..15.
- TIMEOUT, 255, cycles in a wait state before the transaction is aborted; 0 disables the watchdog.

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- i_req_valid  input  1  fetch request
- i_req_ready  output  1  fetch request accepted
- i_req_addr  input  XLEN  fetch address
- i_resp_valid  output  1  fetch response
- i_resp_data  output  XLEN  fetched word
- d_req_valid  input  1  data request
- d_req_ready  output  1  data request accepted
- d_req_addr  input  XLEN  data address
- d_req_data  input  XLEN  store data
- d_req_fcn  input  1  M_XRD=0, M_XWR=1
- d_req_typ  input  3  MT_X=0, MT_B=1, MT_H=2, MT_W=3, MT_BU=5, MT_HU=6, MT_WU=7
- d_resp_valid  output  1  data response (load data, or store ack)
- d_resp_data  output  XLEN  load data
- m_req_valid  output  1  shared port request
- m_req_ready  input  1  memory accepts request
- m_req_addr  output  XLEN  address
- m_req_data  output  XLEN  store data
- m_req_fcn  output  1  function
- m_req_typ  output  3  access type
- m_resp_valid  input  1  memory response
- m_resp_data  input  XLEN  response data
- err_timeout  output  1  sticky watchdog error
- err_stray  output  1  sticky unexpected-response error

Behaviour:
- Clock and reset: one clock, clk. rst is synchronous and active-high.
- Reset values:
  - State is IDLE.
  - Streak and watchdog counters are 0.
  - err_timeout = 0 and err_stray = 0.
  - All valid/ready outputs are 0 during the reset cycle.
- States: IDLE, WAIT_I, WAIT_D.
- Arbitration in IDLE is combinational:
  - Grant dmem when d_req_valid and NOT (i_req_valid and streak == MAX_DSTREAK).
  - Otherwise grant imem if i_req_valid.
- Request path in IDLE:
  - m_req_valid = OR of the granted requester's valid.
  - Payload is muxed from the granted requester.
  - imem payload: fcn = M_XRD, typ = MT_WU, data = 0.
  - Granted x_req_ready = m_req_ready. The non-granted ready is 0.
  - Outside IDLE: m_req_valid = 0 and both readies = 0.
- Handshake rules:
  - A transfer occurs on valid & ready.
  - Requesters hold valid and payload stable until ready.
  - m_req_valid, once raised, stays with the same payload until m_req_ready. Grant must not switch while m_req_valid=1 and m_req_ready=0; latch the grant when it is first raised.
- Transitions:
  - IDLE→WAIT_D on a dmem transfer.
  - IDLE→WAIT_I on an imem transfer.
  - WAIT_x→IDLE on m_resp_valid or on timeout.
  - No new request is issued in the response cycle. The minimum turnaround is 1 cycle, so back-to-back grants are 2 cycles apart plus memory latency.
- Response routing:
  - i_resp_valid = m_resp_valid & (state == WAIT_I).
  - d_resp_valid = m_resp_valid & (state == WAIT_D).
  - Both resp_data outputs are driven from m_resp_data.
  - Store responses are acks; their data is don't-care.
- Streak counter (4-bit, saturating at MAX_DSTREAK):
  - Increments on a dmem transfer while i_req_valid=1.
  - Clears on an imem transfer, or on a dmem transfer with i_req_valid=0.
- Watchdog (TIMEOUT>0 only):
  - Counter clears on entering WAIT_x and increments each wait cycle.
  - When it reaches TIMEOUT without m_resp_valid, pulse x_resp_valid for 1 cycle with data 0, set err_timeout, and return to IDLE.
  - A response arriving in the same cycle as the timeout wins: normal data is returned and no error is raised.
- Stray responses:
  - m_resp_valid in IDLE, including a late response after a timeout or reset, is dropped and sets err_stray.
  - The errors clear only on rst.
- Reset mid-transaction: return to IDLE immediately. No response is delivered to the requester.

Test Plan:
- Only i_req_valid, addr 0x100, m_req_ready=1, response 2 cycles after accept with data 0x00000013 → m_req_fcn=0, m_req_typ=7, then i_resp_valid for 1 cycle with data 0x13; d_resp_valid stays 0.
- i_req_valid and d_req_valid together, d store to 0x2000 with data 0xDEADBEEF and typ=MT_W → dmem granted first (m_req_fcn=1), d_resp_valid ack, then imem granted next IDLE.
- Continuous d and i requests, MAX_DSTREAK=4 → grant order D,D,D,D,I,D,D,D,D,I; streak returns to 0 after each I grant.
- m_req_ready held 0 for 5 cycles with d pending, then i_req_valid rises → payload stays the dmem request and imem is not granted until dmem completes.
- TIMEOUT=8, no response → d_resp_valid with data 0 exactly 8 cycles after accept; err_timeout=1; a late m_resp_valid in IDLE sets err_stray=1.
- rst asserted in WAIT_I → next cycle state is IDLE, outputs are at reset values, and a subsequent response only sets err_stray.
